// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for a common-anode 7-segment bank.
//   Digits are lit one at a time on a shared segment bus. Each digit is
//   preceded by a blanking gap with every anode off, which avoids ghosting.
//   The displayed value is double-buffered: loads land in a pending buffer
//   and only reach the display registers at a frame boundary, so a frame
//   never shows a mix of old and new digits.
//
// Ports
//   clk50m      in   system clock
//   rst         in   synchronous reset, active-high
//   load        in   1-cycle strobe, captures data_in/dp_in as pending value
//   data_in     in   [4*NUM_DIGITS] hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in       in   [NUM_DIGITS] decimal points, 1 = lit
//   lzb_en      in   leading-zero blanking enable (level)
//   seg_n       out  [7] segments {g,f,e,d,c,b,a}, active-low
//   dp_n        out  decimal point, active-low
//   an_n        out  [NUM_DIGITS] anodes, active-low, at most one low
//   frame_done  out  1-cycle pulse in the output cycle of the frame boundary
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk50m,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb_en,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int TMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] SHOW_LAST  = TW'(PRESCALE - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // Scan sequencer
  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          boundary;

  // Double buffer
  logic [NUM_DIGITS-1:0][3:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0][3:0] pend_q, pend_d;
  logic [NUM_DIGITS-1:0]      dpd_q, dpd_d;
  logic [NUM_DIGITS-1:0]      dpp_q, dpp_d;
  logic                       pend_vld_q, pend_vld_d;

  // Registered outputs
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  fd_q, fd_d;

  // Leading-zero blank flag per digit
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [6:0]            seg_act;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Sequencer next state. The timer restarts on every state change; the
  // SHOW->BLANK transition of the last digit is the frame boundary.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + TW'(1);
    idx_d    = idx_q;
    boundary = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (tmr_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          tmr_d   = '0;
        end
      end
      ST_SHOW: begin
        if (tmr_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          tmr_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        tmr_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Double buffer. A load on the boundary cycle bypasses the pending buffer
  // so it is visible in the very next frame and leaves nothing pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_d     = disp_q;
    dpd_d      = dpd_q;
    pend_d     = pend_q;
    dpp_d      = dpp_q;
    pend_vld_d = pend_vld_q;
    if (load) begin
      pend_d     = data_in;
      dpp_d      = dp_in;
      pend_vld_d = 1'b1;
    end
    if (boundary) begin
      if (load) begin
        disp_d = data_in;
        dpd_d  = dp_in;
      end else if (pend_vld_q) begin
        disp_d = pend_q;
        dpd_d  = dpp_q;
      end
      pend_vld_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero detection: digit i>0 blanks when it and every more
  // significant nibble are zero. Digit 0 always shows.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic seen_nz;
    seen_nz  = 1'b0;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen_nz     = seen_nz | (|disp_q[i]);
      lz_blank[i] = ~seen_nz;
    end
  end

  assign seg_act = hex7(disp_q[idx_q]);

  // ---------------------------------------------------------------------------
  // Output decode from the current sequencer state; registered below so pins
  // change only on clock edges and lag the state by one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    an_n_d  = '1;
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    fd_d    = boundary;
    if (state_q == ST_SHOW) begin
      an_n_d[idx_q] = 1'b0;
      // A blanked digit keeps its anode slot so brightness stays uniform.
      if (!(lzb_en && lz_blank[idx_q])) begin
        seg_n_d = ~seg_act;
        dp_n_d  = ~dpd_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      tmr_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      dpd_q      <= '0;
      dpp_q      <= '0;
      pend_vld_q <= 1'b0;
      an_n_q     <= '1;
      seg_n_q    <= 7'h7F;
      dp_n_q     <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      dpd_q      <= dpd_d;
      dpp_q      <= dpp_d;
      pend_vld_q <= pend_vld_d;
      an_n_q     <= an_n_d;
      seg_n_q    <= seg_n_d;
      dp_n_q     <= dp_n_d;
      fd_q       <= fd_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2).
// Stimulus walks frame by frame and queues the hand-decoded digit slots each
// frame should show; the monitor pops one entry per lit slot and checks slot
// length, blanking gap and frame period.
module tb_seg_scan_ctrl;

  logic        clk50m = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        lzb_en;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .PRESCALE    (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk50m    (clk50m),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .lzb_en    (lzb_en),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  always #5 clk50m = ~clk50m;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   mon_en     = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Queue the four slots of one frame; s0..s3 are active-low segment codes,
  // dpn[i] is the expected dp_n of digit i.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpn);
    logic [6:0] s[4];
    logic [3:0] one;
    exp_t       e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    one  = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      e.an  = ~(one << i);
      e.seg = s[i];
      e.dp  = dpn[i];
      q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk50m);
  endtask

  // Returns at the negedge of frame cycle 0 (frame_done high).
  task automatic wait_fd();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk50m);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    check("frame_done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    load = 1'b1; data_in = d; dp_in = dp;
    @(negedge clk50m);
    load = 1'b0;
  endtask

  task automatic check_off(input string nm);
    check(nm, {20'd0, an_n, seg_n, dp_n, frame_done}, {20'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    exp_t cur;
    bit   prev_lit;
    int   lit_len, gap_len, fd_cnt;
    cur = '0; prev_lit = 1'b0; lit_len = 0; gap_len = 0; fd_cnt = 0;
    forever begin
      @(posedge clk50m); #1;
      if (!mon_en) begin
        prev_lit = 1'b0; lit_len = 0; gap_len = 0; fd_cnt = 0;
      end else begin
        fd_cnt++;
        if (frame_done) begin
          check("frame_period", fd_cnt, 24);
          fd_cnt = 0;
        end
        if (an_n != 4'hF) begin
          if (!prev_lit) begin
            check("blank_gap", gap_len, 2);
            if (q.size() == 0) begin
              check("slot_unexpected", {28'd0, an_n}, 32'hF);
            end else begin
              cur = q.pop_front();
            end
            lit_len = 0;
          end
          lit_len++;
          check("slot", {20'd0, an_n, seg_n, dp_n}, {20'd0, cur.an, cur.seg, cur.dp});
          prev_lit = 1'b1;
        end else begin
          if (prev_lit) begin
            check("slot_len", lit_len, 4);
            gap_len = 0;
          end
          gap_len++;
          prev_lit = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; lzb_en = 1'b0;

    // 1. reset for three edges, outputs off throughout
    repeat (3) begin
      @(negedge clk50m);
      check_off("reset_outputs");
    end
    rst = 1'b0;
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);       // F0: 0000
    mon_en = 1'b1;
    wait_cyc(2);
    check("pre_first_digit", {28'd0, an_n}, 32'hF);
    wait_cyc(1);
    check("first_digit_latency", {28'd0, an_n}, 32'hE);

    // 2. 1234 with dp on digit 1
    wait_cyc(2);
    do_load(16'h1234, 4'b0010);
    wait_fd();
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b1101);    // F1: 1234

    // 3. ABCD loaded during digit 1 SHOW, not visible until next frame
    wait_cyc(9);
    do_load(16'hABCD, 4'b0000);
    wait_fd();
    push_frame(7'h21, 7'h46, 7'h03, 7'h08, 4'hF);       // F2: ABCD

    // 4. leading-zero blanking
    wait_cyc(5);
    do_load(16'h0050, 4'b0000);
    wait_fd();
    lzb_en = 1'b1;
    push_frame(7'h40, 7'h12, 7'h7F, 7'h7F, 4'hF);       // F3: 0050 blanked
    wait_cyc(5);
    do_load(16'h0000, 4'b0000);
    wait_fd();
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);       // F4: 0000 blanked

    // 5. last load wins, then a load on the boundary cycle
    wait_cyc(4);
    do_load(16'h1111, 4'b0000);
    wait_cyc(10);
    do_load(16'h2222, 4'b0000);
    wait_fd();
    lzb_en = 1'b0;
    push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'hF);       // F5: 2222
    wait_cyc(23);
    do_load(16'h3333, 4'b1000);                          // sampled on boundary edge
    check("boundary_alignment", {31'd0, frame_done}, 32'd1);
    push_frame(7'h30, 7'h30, 7'h30, 7'h30, 4'b0111);    // F6: 3333

    // 6. reset during digit 2 SHOW with a load pending
    wait_cyc(4);
    do_load(16'h5555, 4'hF);
    wait_cyc(10);
    rst = 1'b1;
    mon_en = 1'b0;
    q.delete();
    @(negedge clk50m);
    check_off("midrun_reset_off");
    @(negedge clk50m);
    check_off("midrun_reset_hold");
    rst = 1'b0;
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);       // 0000 after reset
    mon_en = 1'b1;
    wait_fd();
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);       // pending 5555 discarded
    wait_fd();
    wait_cyc(2);
    mon_en = 1'b0;
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
